// File: rtl/sys_rst_seq.sv
// -----------------------------------------------------------------------------
// sys_rst_seq
//   Power-up reset sequencer. It sits after the 2-FF reset synchronizer and
//   releases the subsystem resets in order: SDRAM controller, camera power,
//   camera reset, camera configuration, then LCD and CNN datapath.
//
//   Ports
//     clk             system clock
//     rst_n           asynchronous active-low reset (already release-synchronized)
//     pll_locked      PLL lock, asynchronous to clk (synchronized internally)
//     sdram_init_done SDRAM controller init complete (level, clk domain)
//     cam_cfg_done    camera SCCB configuration complete (level, clk domain)
//     sdram_rst_n     SDRAM controller reset, active-low
//     cam_pwdn        camera power-down, active-high
//     cam_rst_n       camera hardware reset, active-low
//     cam_cfg_start   one-cycle pulse that starts camera configuration
//     lcd_rst_n       LCD driver reset, active-low
//     cnn_rst_n       CNN/recognition datapath reset, active-low
//     sys_ready       whole sequence complete
//     err_timeout     sticky flag: SDRAM init or camera config timed out
//     state_o         current sequencer state, for debug
// -----------------------------------------------------------------------------
module sys_rst_seq #(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned CAM_PWR_DLY = 50000,
  parameter int unsigned CAM_RST_DLY = 1000000,
  parameter int unsigned INIT_TMO    = 5000000,
  parameter int unsigned TIMER_W     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       cam_cfg_done,
  output logic       sdram_rst_n,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cam_cfg_start,
  output logic       lcd_rst_n,
  output logic       cnn_rst_n,
  output logic       sys_ready,
  output logic       err_timeout,
  output logic [2:0] state_o
);

  localparam int unsigned LCW = $clog2(LOCK_STABLE + 1);

  localparam logic [LCW-1:0]     LOCK_MAX = LCW'(LOCK_STABLE);
  localparam logic [TIMER_W-1:0] PWR_LAST = TIMER_W'(CAM_PWR_DLY - 1);
  localparam logic [TIMER_W-1:0] RST_LAST = TIMER_W'(CAM_RST_DLY - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(INIT_TMO - 1);

  typedef enum logic [2:0] {
    S_LOCK   = 3'd0,
    S_SDRAM  = 3'd1,
    S_CAMPWR = 3'd2,
    S_CAMRST = 3'd3,
    S_CAMCFG = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t               state_reg, state_next;
  logic                 lock_meta_reg, lock_s_reg;
  logic [LCW-1:0]       lock_cnt_reg, lock_cnt_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;

  logic sdram_rst_n_reg, sdram_rst_n_next;
  logic cam_pwdn_reg, cam_pwdn_next;
  logic cam_rst_n_reg, cam_rst_n_next;
  logic cfg_start_reg, cfg_start_next;
  logic lcd_rst_n_reg, lcd_rst_n_next;
  logic cnn_rst_n_reg, cnn_rst_n_next;
  logic sys_ready_reg, sys_ready_next;
  logic err_reg, err_next;

  // Lock filter: any low cycle of the synchronized lock restarts the count.
  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    if (!lock_s_reg) begin
      lock_cnt_next = '0;
    end else if (lock_cnt_reg != LOCK_MAX) begin
      lock_cnt_next = lock_cnt_reg + LCW'(1);
    end
  end

  // Next-state logic. Lock loss has priority in every active state; done
  // beats the timeout when both land on the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOCK: begin
        if (lock_cnt_next == LOCK_MAX) state_next = S_SDRAM;
      end
      S_SDRAM: begin
        if (!lock_s_reg)                 state_next = S_LOCK;
        else if (sdram_init_done)        state_next = S_CAMPWR;
        else if (timer_reg == TMO_LAST)  state_next = S_ERR;
      end
      S_CAMPWR: begin
        if (!lock_s_reg)                 state_next = S_LOCK;
        else if (timer_reg == PWR_LAST)  state_next = S_CAMRST;
      end
      S_CAMRST: begin
        if (!lock_s_reg)                 state_next = S_LOCK;
        else if (timer_reg == RST_LAST)  state_next = S_CAMCFG;
      end
      S_CAMCFG: begin
        if (!lock_s_reg)                 state_next = S_LOCK;
        else if (cam_cfg_done)           state_next = S_RUN;
        else if (timer_reg == TMO_LAST)  state_next = S_ERR;
      end
      S_RUN: begin
        if (!lock_s_reg)                 state_next = S_LOCK;
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: state_next = S_LOCK;
    endcase
  end

  always_comb begin
    timer_next = timer_reg + TIMER_W'(1);
    if (state_next != state_reg) timer_next = '0;
  end

  // Output decode from the current state; the registered result lags the
  // state by one clock. S_ERR freezes whatever had been released so far.
  always_comb begin
    sdram_rst_n_next = 1'b0;
    cam_pwdn_next    = 1'b1;
    cam_rst_n_next   = 1'b0;
    lcd_rst_n_next   = 1'b0;
    cnn_rst_n_next   = 1'b0;
    sys_ready_next   = 1'b0;
    err_next         = err_reg | (state_reg == S_ERR);
    // Timer is zero in S_CAMCFG only on its first cycle, so this is one pulse.
    cfg_start_next   = (state_reg == S_CAMCFG) && (timer_reg == '0);
    case (state_reg)
      S_SDRAM: begin
        sdram_rst_n_next = 1'b1;
      end
      S_CAMPWR: begin
        sdram_rst_n_next = 1'b1;
        cam_pwdn_next    = 1'b0;
      end
      S_CAMRST, S_CAMCFG: begin
        sdram_rst_n_next = 1'b1;
        cam_pwdn_next    = 1'b0;
        cam_rst_n_next   = 1'b1;
      end
      S_RUN: begin
        sdram_rst_n_next = 1'b1;
        cam_pwdn_next    = 1'b0;
        cam_rst_n_next   = 1'b1;
        lcd_rst_n_next   = 1'b1;
        cnn_rst_n_next   = 1'b1;
        sys_ready_next   = 1'b1;
      end
      S_ERR: begin
        sdram_rst_n_next = sdram_rst_n_reg;
        cam_pwdn_next    = cam_pwdn_reg;
        cam_rst_n_next   = cam_rst_n_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_reg   <= 1'b0;
      lock_s_reg      <= 1'b0;
      lock_cnt_reg    <= '0;
      state_reg       <= S_LOCK;
      timer_reg       <= '0;
      sdram_rst_n_reg <= 1'b0;
      cam_pwdn_reg    <= 1'b1;
      cam_rst_n_reg   <= 1'b0;
      cfg_start_reg   <= 1'b0;
      lcd_rst_n_reg   <= 1'b0;
      cnn_rst_n_reg   <= 1'b0;
      sys_ready_reg   <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      lock_meta_reg   <= pll_locked;
      lock_s_reg      <= lock_meta_reg;
      lock_cnt_reg    <= lock_cnt_next;
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      sdram_rst_n_reg <= sdram_rst_n_next;
      cam_pwdn_reg    <= cam_pwdn_next;
      cam_rst_n_reg   <= cam_rst_n_next;
      cfg_start_reg   <= cfg_start_next;
      lcd_rst_n_reg   <= lcd_rst_n_next;
      cnn_rst_n_reg   <= cnn_rst_n_next;
      sys_ready_reg   <= sys_ready_next;
      err_reg         <= err_next;
    end
  end

  assign sdram_rst_n   = sdram_rst_n_reg;
  assign cam_pwdn      = cam_pwdn_reg;
  assign cam_rst_n     = cam_rst_n_reg;
  assign cam_cfg_start = cfg_start_reg;
  assign lcd_rst_n     = lcd_rst_n_reg;
  assign cnn_rst_n     = cnn_rst_n_reg;
  assign sys_ready     = sys_ready_reg;
  assign err_timeout   = err_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_sys_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_sys_rst_seq
//   Scoreboard bench for sys_rst_seq. Each scenario computes its milestone
//   cycles (lock reached, each wait-state exit) with plain arithmetic, expands
//   them into the expected output vector per cycle and queues every change.
//   A negedge monitor pops one entry each time the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_sys_rst_seq;

  localparam int L   = 4;
  localparam int PWR = 3;
  localparam int RST = 5;
  localparam int TMO = 20;

  // {state_o, sdram_rst_n, cam_pwdn, cam_rst_n, cam_cfg_start, lcd, cnn, ready, err}
  localparam logic [10:0] RESET_VEC = {3'd0, 1'b0, 1'b1, 6'b000000};

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       cam_cfg_done;
  logic       sdram_rst_n, cam_pwdn, cam_rst_n, cam_cfg_start;
  logic       lcd_rst_n, cnn_rst_n, sys_ready, err_timeout;
  logic [2:0] state_o;
  logic [10:0] dut_vec;

  sys_rst_seq #(
    .LOCK_STABLE(L), .CAM_PWR_DLY(PWR), .CAM_RST_DLY(RST),
    .INIT_TMO(TMO), .TIMER_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .sdram_init_done(sdram_init_done), .cam_cfg_done(cam_cfg_done),
    .sdram_rst_n(sdram_rst_n), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .cam_cfg_start(cam_cfg_start), .lcd_rst_n(lcd_rst_n), .cnn_rst_n(cnn_rst_n),
    .sys_ready(sys_ready), .err_timeout(err_timeout), .state_o(state_o)
  );

  assign dut_vec = {state_o, sdram_rst_n, cam_pwdn, cam_rst_n, cam_cfg_start,
                    lcd_rst_n, cnn_rst_n, sys_ready, err_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          c;
    logic [10:0] v;
  } ev_t;
  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [10:0] exp_prev;
  logic [10:0] mon_prev;
  bit          mon_en = 1'b0;

  // Milestones for up to two lock epochs (second one only after a lock loss).
  int ep_E[2], ep_A[2], ep_B[2], ep_C[2];
  bit ep_ok1[2], ep_ok2[2];
  int loss_q = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // p: cycle after which pll_locked is driven high and then stays high.
  // k: done first seen k cycles after wait-state entry (k=1: already high).
  task automatic calc_epoch(input int e, input int p, input int k1, input int k2);
    ep_E[e]   = p + 2 + L;
    ep_ok1[e] = (k1 <= TMO);
    ep_A[e]   = ep_E[e] + (ep_ok1[e] ? k1 : TMO);
    ep_B[e]   = ep_A[e] + PWR + RST;
    ep_ok2[e] = (k2 <= TMO);
    ep_C[e]   = ep_B[e] + (ep_ok2[e] ? k2 : TMO);
  endtask

  function automatic logic [2:0] state_at(input int c, input int e);
    if (c < ep_E[e])           return 3'd0;
    if (c < ep_A[e])           return 3'd1;
    if (!ep_ok1[e])            return 3'd6;
    if (c < ep_A[e] + PWR)     return 3'd2;
    if (c < ep_B[e])           return 3'd3;
    if (c < ep_C[e])           return 3'd4;
    return ep_ok2[e] ? 3'd5 : 3'd6;
  endfunction

  function automatic logic [10:0] exp_vec(input int c);
    int   es, eo;
    logic sd, pw, cr, cs, run, er;
    es  = (loss_q >= 0 && c >= loss_q + 3) ? 1 : 0;
    eo  = (loss_q >= 0 && c >= loss_q + 4) ? 1 : 0;
    sd  = (c >= ep_E[eo] + 1);
    pw  = !(ep_ok1[eo] && c >= ep_A[eo] + 1);
    cr  = ep_ok1[eo] && (c >= ep_A[eo] + PWR + 1);
    cs  = ep_ok1[eo] && (c == ep_B[eo] + 1);
    run = ep_ok1[eo] && ep_ok2[eo] && (c >= ep_C[eo] + 1);
    er  = (!ep_ok1[eo] && c >= ep_A[eo] + 1) ||
          (ep_ok1[eo] && !ep_ok2[eo] && c >= ep_C[eo] + 1);
    return {state_at(c, es), sd, pw, cr, cs, run, run, run, er};
  endfunction

  task automatic push_model(input int from_c, input int to_c);
    logic [10:0] v;
    ev_t         e;
    for (int c = from_c; c <= to_c; c++) begin
      v = exp_vec(c);
      if (v !== exp_prev) begin
        e.c = c;
        e.v = v;
        exp_q.push_back(e);
      end
      exp_prev = v;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output change must match the head of the queue, both in
  // value and in the cycle it happened.
  always @(negedge clk) begin
    if (mon_en && (dut_vec !== mon_prev)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b want=no_change", cyc, dut_vec);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.c != cyc || mon_e.v !== dut_vec) begin
          n_bad++;
          $display("FAIL out_event got cyc=%0d vec=%b want cyc=%0d vec=%b",
                   cyc, dut_vec, mon_e.c, mon_e.v);
        end
      end
      mon_prev = dut_vec;
    end
  end

  // kind: 0 directed, 1 sdram timeout + lock glitch in S_ERR, 2 lock loss in
  // S_RUN, 3 lock toggling, 4 reset during S_CAMRST, 5/6/7 done/timeout mixes.
  task automatic run_scn(input int kind, input int k1, input int k2);
    int r0, p, rend;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    r0 = cyc;
    #1;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    cam_cfg_done = 1'b0;
    #1;
    chk("async_reset_vec", dut_vec, RESET_VEC);
    p = r0 + 2 + int'($urandom_range(0, 3));
    loss_q = -1;
    calc_epoch(0, p, k1, k2);
    calc_epoch(1, p, k1, k2);
    case (kind)
      1: rend = ep_A[0] + 10;
      2: begin
        loss_q = ep_C[0] + 3;
        calc_epoch(1, loss_q + 1, 1, 1);
        rend = ep_C[1] + 4;
      end
      3: begin
        calc_epoch(0, 1 << 28, 1, 1);
        rend = p + 40;
      end
      4: rend = ep_A[0] + PWR + 2;
      default: rend = (ep_ok1[0] ? ep_C[0] : ep_A[0]) + 4;
    endcase
    $display("scenario kind=%0d k1=%0d k2=%0d start=%0d end=%0d", kind, k1, k2, r0, rend);
    push_model(r0, rend - 1);
    wait_cyc(r0 + 1);
    rst_n = 1'b1;
    if (kind == 3) begin
      for (int i = 0; i < 5; i++) begin
        wait_cyc(p + 6 * i);
        pll_locked = 1'b1;
        wait_cyc(p + 6 * i + 3);
        pll_locked = 1'b0;
      end
    end else begin
      wait_cyc(p);
      pll_locked = 1'b1;
      if (k1 <= TMO + 2 && ep_E[0] + k1 - 1 < rend) begin
        wait_cyc(ep_E[0] + k1 - 1);
        sdram_init_done = 1'b1;
      end
      if (ep_ok1[0] && ep_B[0] + k2 - 1 < rend) begin
        wait_cyc(ep_B[0] + k2 - 1);
        cam_cfg_done = 1'b1;
      end
      if (kind == 1) begin
        wait_cyc(ep_A[0] + 3);
        pll_locked = 1'b0;
        wait_cyc(ep_A[0] + 4);
        pll_locked = 1'b1;
      end
      if (kind == 2) begin
        wait_cyc(loss_q);
        pll_locked = 1'b0;
        wait_cyc(loss_q + 1);
        pll_locked = 1'b1;
      end
    end
    wait_cyc(rend);
    if (kind == 3) begin
      chk("toggle_sdram_held", sdram_rst_n, 1'b0);
      chk("toggle_state_lock", state_o, 3'd0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    cam_cfg_done = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_vec, RESET_VEC);
    mon_prev = dut_vec;
    exp_prev = RESET_VEC;
    mon_en = 1'b1;

    run_scn(0, 2, 2);
    run_scn(1, TMO + 5, 1);
    run_scn(2, 2, 2);
    run_scn(3, 1, 1);
    run_scn(4, 2, 2);
    run_scn(5, 2, TMO);
    run_scn(6, TMO, TMO + 1);
    for (int i = 0; i < 10; i++) begin
      run_scn(7, int'($urandom_range(1, TMO + 2)), int'($urandom_range(1, TMO + 2)));
    end

    wait_cyc(cyc + 3);
    chk("queue_drained_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
